cp_remover: RTL and testbench
=============================

# cp_remover

Downstream consumer of the sample FIFO in the receive chain: takes the time-domain IQ stream from the FIFO output, drops each OFDM symbol's cyclic prefix and forwards exactly FFT_LEN samples per symbol to the FFT. Symbol framing is anchored by a `sync_i` pulse from the timing/PSS stage. Each output symbol is marked with `tlast` on its final sample and carries the in-slot symbol index on `tuser`. Backpressure from the FFT propagates to the FIFO via `s_axis_in_tready`.

## Interface
- `IN_DW`, 32: IQ sample width (I and Q packed).
- `FFT_LEN`, 256: forwarded samples per symbol; ≥ 2.
- `CP_LEN`, 18: normal CP length in samples; ≥ 1.
- `CP_EXTRA`, 2: extra CP samples on long-CP symbols; ≥ 0.
- `SYMS_PER_SLOT`, 14: symbols per slot, even, ≤ 16.
- `clk_i` in 1: single clock, same domain as the FIFO output.
- `reset_ni` in 1: asynchronous, active-low reset.
- `s_axis_in_tdata` in IN_DW: input samples.
- `s_axis_in_tvalid` in 1: input valid.
- `s_axis_in_tready` out 1: input ready.
- `sync_i` in 1: one-cycle pulse marking the first CP sample of symbol 0.
- `m_axis_out_tdata` out IN_DW: CP-stripped samples.
- `m_axis_out_tvalid` out 1: output valid.
- `m_axis_out_tready` in 1: downstream ready.
- `m_axis_out_tlast` out 1: last sample of a symbol.
- `m_axis_out_tuser` out 4: symbol index within the slot, 0..SYMS_PER_SLOT-1.
- `locked_o` out 1: high from the first `sync_i` onwards.

## Operation
- States:
  - IDLE (reset state): discards all input, `s_axis_in_tready`=1. Leaves to SKIP_CP on `sync_i`.
  - SKIP_CP: discards input, `s_axis_in_tready`=1. Counts CP samples, then goes to PASS.
  - PASS: forwards input, `s_axis_in_tready` = `!m_axis_out_tvalid || m_axis_out_tready`.
- Sample accepted ⇔ `s_axis_in_tvalid && s_axis_in_tready`. Only accepted samples advance counters.
- `sync_i` (any state):
  - Next cycle: state=SKIP_CP, sample counter=0, symbol index=0, `locked_o`=1.
  - If a sample is accepted in the same cycle as `sync_i`, it counts as CP sample 0 of symbol 0.
  - Pending output register contents are kept and delivered normally. A resync mid-PASS truncates that symbol without asserting `tlast`.
- SKIP_CP:
  - CP length is CP_LEN + CP_EXTRA when the symbol index is 0 or SYMS_PER_SLOT/2, otherwise CP_LEN.
  - Transition to PASS on acceptance of the final CP sample, with the counter reset to 0.
- PASS:
  - Accepted sample is loaded into the output register.
  - `tlast` = (counter == FFT_LEN-1); `tuser` = current symbol index.
  - On acceptance of sample FFT_LEN-1: return to SKIP_CP, symbol index += 1, wrapping SYMS_PER_SLOT-1 → 0.
- Counter width: $clog2(FFT_LEN+CP_LEN+CP_EXTRA). It never exceeds its terminal value.
- The output register holds data, tlast and tuser stable while `tvalid && !tready`.

## Timing
- Reset values: `m_axis_out_tvalid`=0, `tdata`=0, `tlast`=0, `tuser`=0, `locked_o`=0, state=IDLE.
- `s_axis_in_tready` is 1 during reset deassertion.
- Latency: a sample accepted in PASS in cycle n is valid on the output in cycle n+1.
- Full throughput: 1 sample/cycle in PASS with `m_axis_out_tready`=1.
- `s_axis_in_tready` is combinational from state, `m_axis_out_tvalid` and `m_axis_out_tready`. There is no combinational path from `s_axis_in_tvalid` to `s_axis_in_tready`.
- A gap in `s_axis_in_tvalid` stalls counters; no samples are lost or duplicated.
- `m_axis_out_tvalid` drops the cycle after the last held sample is taken with no new accept.
- Reset asserted mid-symbol: all state clears immediately; IDLE until the next `sync_i`.

## Configuration
- `CP_REMOVER_LONG_CP_EN` defined: long-CP handling as above (symbols 0 and SYMS_PER_SLOT/2 skip CP_LEN+CP_EXTRA).
- Not defined: every symbol skips CP_LEN. CP_EXTRA is ignored and no logic is generated for it.

## Test plan
Bench parameters: FFT_LEN=8, CP_LEN=2, CP_EXTRA=1, SYMS_PER_SLOT=4, ramp input 0,1,2,…, `m_axis_out_tready`=1.

1. Ramp before any sync → no output, `locked_o`=0. `sync_i` on sample 10, macro defined → output 13..20 with `tlast` on 20, `tuser`=0; then 23..30 with `tuser`=1.
2. Macro undefined, same stimulus → outputs 12..19, then 22..29.
3. Full slot → `tuser` sequence 0,1,2,3,0. Symbol 2 skips 3 samples, symbols 1 and 3 skip 2.
4. `m_axis_out_tready` toggled 1/0 every cycle, random input valid gaps → output sequence identical to test 1, and `tdata`, `tlast`, `tuser` stable while stalled.
5. Second `sync_i` at PASS sample 4 → that symbol ends without `tlast`; the next output is sync sample + 3, with `tuser`=0.
6. Reset asserted mid-PASS → next cycle `tvalid`=0, `locked_o`=0; no output until a new `sync_i`.

Source files
------------

// File: rtl/cp_remover.sv
// Cyclic-prefix remover: discards each OFDM symbol's CP and forwards FFT_LEN samples with tlast/tuser framing.
// Define CP_REMOVER_LONG_CP_EN to give symbols 0 and SYMS_PER_SLOT/2 an extra CP_EXTRA prefix samples.
module cp_remover #(
    parameter int IN_DW         = 32,
    parameter int FFT_LEN       = 256,
    parameter int CP_LEN        = 18,
    parameter int CP_EXTRA      = 2,
    parameter int SYMS_PER_SLOT = 14
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic [IN_DW-1:0] s_axis_in_tdata,
    input  logic             s_axis_in_tvalid,
    output logic             s_axis_in_tready,
    input  logic             sync_i,
    output logic [IN_DW-1:0] m_axis_out_tdata,
    output logic             m_axis_out_tvalid,
    input  logic             m_axis_out_tready,
    output logic             m_axis_out_tlast,
    output logic [3:0]       m_axis_out_tuser,
    output logic             locked_o
);

    localparam int CNT_W = $clog2(FFT_LEN + CP_LEN + CP_EXTRA);
    localparam logic [CNT_W-1:0] FFT_LAST      = CNT_W'(FFT_LEN - 1);
    localparam logic [CNT_W-1:0] CP_SHORT_LAST = CNT_W'(CP_LEN - 1);
    localparam logic [3:0]       SYM_LAST      = 4'(SYMS_PER_SLOT - 1);
`ifdef CP_REMOVER_LONG_CP_EN
    localparam logic [CNT_W-1:0] CP_LONG_LAST  = CNT_W'(CP_LEN + CP_EXTRA - 1);
    localparam logic [3:0]       SYM_HALF      = 4'(SYMS_PER_SLOT / 2);
    localparam logic [CNT_W-1:0] SYNC_CP_LAST  = CP_LONG_LAST;
`else
    localparam logic [CNT_W-1:0] SYNC_CP_LAST  = CP_SHORT_LAST;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SKIP = 2'd1,
        ST_PASS = 2'd2
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       sym_r;
    logic             locked_r;
    logic [IN_DW-1:0] out_data_r;
    logic             out_valid_r;
    logic             out_last_r;
    logic [3:0]       out_user_r;

    logic             in_ready_s;
    logic             accept_s;
    logic [CNT_W-1:0] cp_last_s;

    // Input ready: only PASS is subject to output backpressure.
    always_comb begin
        in_ready_s = 1'b1;
        case (state_r)
            ST_PASS: in_ready_s = !out_valid_r || m_axis_out_tready;
            default: in_ready_s = 1'b1;
        endcase
    end

    assign accept_s = s_axis_in_tvalid && in_ready_s;

    // Final CP sample index for the current symbol.
    always_comb begin
`ifdef CP_REMOVER_LONG_CP_EN
        if ((sym_r == 4'd0) || (sym_r == SYM_HALF)) begin
            cp_last_s = CP_LONG_LAST;
        end else begin
            cp_last_s = CP_SHORT_LAST;
        end
`else
        cp_last_s = CP_SHORT_LAST;
`endif
    end

    // Framing FSM, counters and output register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            sym_r       <= 4'd0;
            locked_r    <= 1'b0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_user_r  <= 4'd0;
        end else begin
            if (out_valid_r && m_axis_out_tready) begin
                out_valid_r <= 1'b0;
            end
            // A sample arriving with sync belongs to the new symbol's CP, never to the output.
            if ((state_r == ST_PASS) && accept_s && !sync_i) begin
                out_data_r  <= s_axis_in_tdata;
                out_valid_r <= 1'b1;
                out_last_r  <= (cnt_r == FFT_LAST);
                out_user_r  <= sym_r;
            end

            if (sync_i) begin
                locked_r <= 1'b1;
                sym_r    <= 4'd0;
                if (accept_s && (SYNC_CP_LAST == '0)) begin
                    state_r <= ST_PASS;
                    cnt_r   <= '0;
                end else begin
                    state_r <= ST_SKIP;
                    cnt_r   <= accept_s ? CNT_W'(1) : '0;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_SKIP: begin
                        if (accept_s) begin
                            if (cnt_r == cp_last_s) begin
                                state_r <= ST_PASS;
                                cnt_r   <= '0;
                            end else begin
                                cnt_r   <= cnt_r + CNT_W'(1);
                            end
                        end
                    end
                    ST_PASS: begin
                        if (accept_s) begin
                            if (cnt_r == FFT_LAST) begin
                                state_r <= ST_SKIP;
                                cnt_r   <= '0;
                                sym_r   <= (sym_r == SYM_LAST) ? 4'd0 : sym_r + 4'd1;
                            end else begin
                                cnt_r   <= cnt_r + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                    end
                endcase
            end
        end
    end

    assign s_axis_in_tready  = in_ready_s;
    assign m_axis_out_tdata  = out_data_r;
    assign m_axis_out_tvalid = out_valid_r;
    assign m_axis_out_tlast  = out_last_r;
    assign m_axis_out_tuser  = out_user_r;
    assign locked_o          = locked_r;

endmodule

// File: tb/tb_cp_remover.sv
// Directed bench for cp_remover: ramp input, hand-derived symbol boundaries, backpressure and resync cases.
module tb_cp_remover;

    localparam int DW  = 32;
    localparam int FL  = 8;
    localparam int CPL = 2;
    localparam int CPE = 1;
    localparam int SPS = 4;
`ifdef CP_REMOVER_LONG_CP_EN
    localparam int CP_LONG = CPL + CPE;
`else
    localparam int CP_LONG = CPL;
`endif

    logic          clk = 1'b0;
    logic          reset_ni = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          s_sync = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          m_last;
    logic [3:0]    m_user;
    logic          locked;

    cp_remover #(
        .IN_DW(DW), .FFT_LEN(FL), .CP_LEN(CPL), .CP_EXTRA(CPE), .SYMS_PER_SLOT(SPS)
    ) dut (
        .clk_i(clk), .reset_ni(reset_ni),
        .s_axis_in_tdata(s_data), .s_axis_in_tvalid(s_valid), .s_axis_in_tready(s_ready),
        .sync_i(s_sync),
        .m_axis_out_tdata(m_data), .m_axis_out_tvalid(m_valid), .m_axis_out_tready(m_ready),
        .m_axis_out_tlast(m_last), .m_axis_out_tuser(m_user), .locked_o(locked)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    int smp = 0;
    int sync_a = -1;
    int sync_b = -1;
    bit gap_en = 1'b0;
    bit tog_en = 1'b0;

    logic [DW-1:0] q_data[$];
    logic          q_last[$];
    logic [3:0]    q_user[$];
    int            exp_data[$];
    bit            exp_last[$];
    int            exp_user[$];

    int            stall_viol = 0;
    int            stall_seen = 0;
    logic          held = 1'b0;
    logic [DW-1:0] h_data;
    logic          h_last;
    logic [3:0]    h_user;

    // Output monitor: records transfers and watches held beats for stability.
    always @(negedge clk) begin
        if (!reset_ni) begin
            held = 1'b0;
        end else begin
            if (held && (m_valid !== 1'b1 || m_data !== h_data || m_last !== h_last || m_user !== h_user))
                stall_viol++;
            held = m_valid && !m_ready;
            h_data = m_data;
            h_last = m_last;
            h_user = m_user;
            if (held) stall_seen++;
            if (m_valid && m_ready) begin
                q_data.push_back(m_data);
                q_last.push_back(m_last);
                q_user.push_back(m_user);
            end
        end
    end

    task automatic cycle();
        logic acc;
        s_valid = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        s_data  = DW'(smp);
        s_sync  = s_valid && ((smp == sync_a) || (smp == sync_b));
        if (s_sync) begin
            if (smp == sync_a) sync_a = -1;
            if (smp == sync_b) sync_b = -1;
        end
        m_ready = tog_en ? ~m_ready : 1'b1;
        @(negedge clk);
        acc = s_valid && s_ready;
        @(posedge clk);
        #1;
        s_sync = 1'b0;
        if (acc) smp++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        reset_ni = 1'b0;
        s_valid = 1'b0;
        s_sync = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_ni = 1'b1;
        @(posedge clk);
        #1;
        q_data.delete(); q_last.delete(); q_user.delete();
        exp_data.delete(); exp_last.delete(); exp_user.delete();
        smp = 0; sync_a = -1; sync_b = -1;
        gap_en = 1'b0; tog_en = 1'b0;
        stall_viol = 0; stall_seen = 0;
    endtask

    // Expected symbols following a sync on ramp value sync_smp.
    task automatic build_exp(input int sync_smp, input int nsyms);
        int pos;
        int idx;
        pos = sync_smp;
        for (int k = 0; k < nsyms; k++) begin
            idx = k % SPS;
            pos += ((idx == 0) || (idx == SPS / 2)) ? CP_LONG : CPL;
            for (int j = 0; j < FL; j++) begin
                exp_data.push_back(pos + j);
                exp_last.push_back(j == FL - 1);
                exp_user.push_back(idx);
            end
            pos += FL;
        end
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        #3;
        vec_cnt++;
        if ({s_ready, m_valid, m_last, locked} !== 4'b1000 || m_data !== '0 || m_user !== 4'd0) begin
            err_cnt++;
            $display("FAIL reset: ready/valid/last/locked=%b%b%b%b data=%0h user=%0d, required 1000 data=0 user=0",
                     s_ready, m_valid, m_last, locked, m_data, m_user);
        end
    endtask

    task automatic test_pre_sync();
        do_reset();
        run(10);
        vec_cnt++;
        if (q_data.size() !== 0 || locked !== 1'b0) begin
            err_cnt++;
            $display("FAIL pre_sync: outputs=%0d locked=%b, required 0 and 0", q_data.size(), locked);
        end
    endtask

    task automatic test_first_symbols();
        do_reset();
        sync_a = 10;
        run(40);
        build_exp(10, 2);
        vec_cnt++;
        if (locked !== 1'b1) begin
            err_cnt++;
            $display("FAIL first_locked: got %b, required 1", locked);
        end
        vec_cnt++;
        if (q_data.size() < exp_data.size()) begin
            err_cnt++;
            $display("FAIL first_count: got %0d, required >= %0d", q_data.size(), exp_data.size());
        end else begin
            for (int i = 0; i < exp_data.size(); i++) begin
                vec_cnt++;
                if (q_data[i] !== DW'(exp_data[i]) || q_last[i] !== exp_last[i] || q_user[i] !== 4'(exp_user[i])) begin
                    err_cnt++;
                    $display("FAIL first[%0d]: got %0d/%b/%0d, required %0d/%b/%0d", i,
                             q_data[i], q_last[i], q_user[i], exp_data[i], exp_last[i], exp_user[i]);
                end
            end
        end
    endtask

    task automatic test_full_slot();
        do_reset();
        sync_a = 10;
        run(75);
        build_exp(10, 5);
        vec_cnt++;
        if (q_data.size() < exp_data.size()) begin
            err_cnt++;
            $display("FAIL slot_count: got %0d, required >= %0d", q_data.size(), exp_data.size());
        end else begin
            for (int i = 0; i < exp_data.size(); i++) begin
                vec_cnt++;
                if (q_data[i] !== DW'(exp_data[i]) || q_last[i] !== exp_last[i] || q_user[i] !== 4'(exp_user[i])) begin
                    err_cnt++;
                    $display("FAIL slot[%0d]: got %0d/%b/%0d, required %0d/%b/%0d", i,
                             q_data[i], q_last[i], q_user[i], exp_data[i], exp_last[i], exp_user[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        gap_en = 1'b1;
        tog_en = 1'b1;
        sync_a = 10;
        run(250);
        tog_en = 1'b0;
        gap_en = 1'b0;
        build_exp(10, 2);
        vec_cnt++;
        if (stall_viol !== 0 || stall_seen == 0) begin
            err_cnt++;
            $display("FAIL bp_stable: violations=%0d stalls=%0d, required 0 and >0", stall_viol, stall_seen);
        end
        vec_cnt++;
        if (q_data.size() < exp_data.size()) begin
            err_cnt++;
            $display("FAIL bp_count: got %0d, required >= %0d", q_data.size(), exp_data.size());
        end else begin
            for (int i = 0; i < exp_data.size(); i++) begin
                vec_cnt++;
                if (q_data[i] !== DW'(exp_data[i]) || q_last[i] !== exp_last[i] || q_user[i] !== 4'(exp_user[i])) begin
                    err_cnt++;
                    $display("FAIL bp[%0d]: got %0d/%b/%0d, required %0d/%b/%0d", i,
                             q_data[i], q_last[i], q_user[i], exp_data[i], exp_last[i], exp_user[i]);
                end
            end
        end
    endtask

    task automatic test_resync();
        do_reset();
        sync_a = 10;
        sync_b = 10 + CP_LONG + 4;
        run(40);
        for (int j = 0; j < 4; j++) begin
            exp_data.push_back(10 + CP_LONG + j);
            exp_last.push_back(1'b0);
            exp_user.push_back(0);
        end
        build_exp(10 + CP_LONG + 4, 1);
        vec_cnt++;
        if (q_data.size() < exp_data.size()) begin
            err_cnt++;
            $display("FAIL resync_count: got %0d, required >= %0d", q_data.size(), exp_data.size());
        end else begin
            for (int i = 0; i < exp_data.size(); i++) begin
                vec_cnt++;
                if (q_data[i] !== DW'(exp_data[i]) || q_last[i] !== exp_last[i] || q_user[i] !== 4'(exp_user[i])) begin
                    err_cnt++;
                    $display("FAIL resync[%0d]: got %0d/%b/%0d, required %0d/%b/%0d", i,
                             q_data[i], q_last[i], q_user[i], exp_data[i], exp_last[i], exp_user[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        sync_a = 10;
        run(16);
        vec_cnt++;
        if (m_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL mid_active: valid=%b, required 1", m_valid);
        end
        reset_ni = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (m_valid !== 1'b0 || locked !== 1'b0 || s_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL mid_reset: valid=%b locked=%b ready=%b, required 0 0 1", m_valid, locked, s_ready);
        end
        @(posedge clk);
        #1;
        reset_ni = 1'b1;
        q_data.delete(); q_last.delete(); q_user.delete();
        run(30);
        vec_cnt++;
        if (q_data.size() !== 0 || locked !== 1'b0) begin
            err_cnt++;
            $display("FAIL mid_after: outputs=%0d locked=%b, required 0 and 0", q_data.size(), locked);
        end
    endtask

    initial begin
        test_reset();
        test_pre_sync();
        test_first_symbols();
        test_full_slot();
        test_backpressure();
        test_resync();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
